// File: rtl/abstract_cmd_seq_pkg.sv
// Shared debug definitions for the abstract-command sequencer: state type,
// cmderr codes, GPR regno window and legality helpers.
package abstract_cmd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_HALT_WAIT   = 3'd1,
    ST_ACCESS      = 3'd2,
    ST_CAPTURE     = 3'd3,
    ST_RESUME_WAIT = 3'd4
  } seq_state_e;

  localparam logic [2:0]  CMDERR_NONE       = 3'd0;
  localparam logic [2:0]  CMDERR_BUSY       = 3'd1;
  localparam logic [2:0]  CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0]  CMDERR_EXCEPTION  = 3'd3;
  localparam logic [2:0]  CMDERR_HALTRESUME = 3'd4;

  localparam logic [15:0] REGNO_GPR_BASE    = 16'h1000;
  localparam logic [2:0]  AARSIZE_32        = 3'd2;

  // GPRs occupy the 32-entry window starting at REGNO_GPR_BASE
  function automatic logic is_gpr_regno(input logic [15:0] regno);
    return (regno[15:5] == REGNO_GPR_BASE[15:5]);
  endfunction

  function automatic logic cmd_illegal(input logic        postexec,
                                       input logic        transfer,
                                       input logic [2:0]  aarsize,
                                       input logic [15:0] regno);
    return postexec ||
           (transfer && ((aarsize != AARSIZE_32) || !is_gpr_regno(regno)));
  endfunction

endpackage

// File: rtl/abstract_cmd_seq_dbg_timeout.sv
// Loadable down-counter bounding the halt/resume handshakes; Expired is high
// while the count sits at zero.
module abstract_cmd_seq_dbg_timeout #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             Expired
);

  logic [WIDTH-1:0] count_r;

  // count down while enabled, saturating at zero
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (en && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign Expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/abstract_cmd_seq.sv
// Debug Module "Access Register" sequencer driving the core's debug register
// port. Define ABSTRACT_AUTOHALT_EN to halt/resume a running core around an access.
module abstract_cmd_seq
  import abstract_cmd_seq_pkg::*;
#(
  parameter int HALT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        sys_reset,
  input  logic        CmdValid,
  input  logic [15:0] CmdRegno,
  input  logic        CmdWrite,
  input  logic        CmdTransfer,
  input  logic        CmdPostexec,
  input  logic [2:0]  CmdAarsize,
  input  logic [31:0] Data0In,
  input  logic        CmdErrClr,
  output logic        CmdBusy,
  output logic [2:0]  CmdErr,
  output logic [31:0] Data0Out,
  output logic        Data0We,
  input  logic        DebugMode,
  output logic        HaltReq,
  output logic        ResumeReq,
  output logic        DebugControl,
  output logic [4:0]  RegAddr,
  output logic [31:0] RegIn,
  output logic        DebugRegWrite,
  input  logic [31:0] RegOut
);

  seq_state_e  state_r, state_s;
  logic [2:0]  err_s;
  logic        latch_s;
  logic [4:0]  regno_r;
  logic        write_r;
  logic [31:0] data0_r;

  logic [4:0]  acc_addr_s;
  logic        acc_write_s;
  logic [31:0] acc_data_s;

  logic        ctl_s, regwr_s, d0we_s, halt_s, resume_s;
  logic [4:0]  addr_s;
  logic [31:0] regin_s, d0out_s;

`ifdef ABSTRACT_AUTOHALT_EN
  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  logic auto_r;
  logic tload_s;
  logic expired_s;

  abstract_cmd_seq_dbg_timeout #(.WIDTH(TW)) u_timeout (
    .clk        (clk),
    .sys_reset  (sys_reset),
    .load       (tload_s),
    .load_value (TW'(HALT_TIMEOUT)),
    .en         ((state_r == ST_HALT_WAIT) || (state_r == ST_RESUME_WAIT)),
    .Expired    (expired_s)
  );
`endif

  // next state, cmderr update and next values of the registered port outputs
  always_comb begin
    state_s  = state_r;
    latch_s  = 1'b0;
    ctl_s    = 1'b0;
    addr_s   = 5'd0;
    regin_s  = 32'd0;
    regwr_s  = 1'b0;
    d0we_s   = 1'b0;
    d0out_s  = Data0Out;
    halt_s   = 1'b0;
    resume_s = 1'b0;
`ifdef ABSTRACT_AUTOHALT_EN
    tload_s  = 1'b0;
`endif

    // the accepting cycle uses live inputs; a deferred access uses the latch
    if (state_r == ST_IDLE) begin
      acc_addr_s  = CmdRegno[4:0];
      acc_write_s = CmdWrite;
      acc_data_s  = Data0In;
    end else begin
      acc_addr_s  = regno_r;
      acc_write_s = write_r;
      acc_data_s  = data0_r;
    end

    if (CmdErrClr) begin
      err_s = CMDERR_NONE;
    end else begin
      err_s = CmdErr;
    end

    if ((state_r != ST_IDLE) && CmdValid && (CmdErr == CMDERR_NONE)) begin
      err_s = CMDERR_BUSY;
    end else begin
      err_s = err_s;
    end

    case (state_r)
      ST_IDLE: begin
        if (CmdValid && (CmdErr == CMDERR_NONE)) begin
          if (cmd_illegal(CmdPostexec, CmdTransfer, CmdAarsize, CmdRegno)) begin
            err_s = CMDERR_NOTSUP;
          end else if (!CmdTransfer) begin
            state_s = ST_IDLE;
          end else if (DebugMode) begin
            state_s = ST_ACCESS;
            latch_s = 1'b1;
          end else begin
`ifdef ABSTRACT_AUTOHALT_EN
            state_s = ST_HALT_WAIT;
            latch_s = 1'b1;
            halt_s  = 1'b1;
            tload_s = 1'b1;
`else
            err_s   = CMDERR_HALTRESUME;
`endif
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
`ifdef ABSTRACT_AUTOHALT_EN
      ST_HALT_WAIT: begin
        if (DebugMode) begin
          state_s = ST_ACCESS;
        end else if (expired_s) begin
          state_s = ST_IDLE;
          err_s   = CMDERR_HALTRESUME;
        end else begin
          halt_s  = 1'b1;
        end
      end
      ST_RESUME_WAIT: begin
        if (!DebugMode) begin
          state_s  = ST_IDLE;
        end else if (expired_s) begin
          state_s  = ST_IDLE;
          err_s    = CMDERR_HALTRESUME;
        end else begin
          resume_s = 1'b1;
        end
      end
`endif
      ST_ACCESS: begin
        state_s = ST_CAPTURE;
      end
      ST_CAPTURE: begin
`ifdef ABSTRACT_AUTOHALT_EN
        if (auto_r) begin
          state_s  = ST_RESUME_WAIT;
          resume_s = 1'b1;
          tload_s  = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // port values for the state being entered; x0 writes are swallowed
    case (state_s)
      ST_ACCESS: begin
        ctl_s   = 1'b1;
        addr_s  = acc_addr_s;
        regwr_s = acc_write_s && (acc_addr_s != 5'd0);
        regin_s = regwr_s ? acc_data_s : 32'd0;
      end
      ST_CAPTURE: begin
        ctl_s  = 1'b1;
        addr_s = regno_r;
        if (!write_r) begin
          d0we_s  = 1'b1;
          d0out_s = (regno_r == 5'd0) ? 32'd0 : RegOut;
        end else begin
          d0we_s  = 1'b0;
        end
      end
      default: begin
        ctl_s = 1'b0;
      end
    endcase
  end

  // state and registered outputs; reset aborts any command in flight
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_r       <= ST_IDLE;
      CmdBusy       <= 1'b0;
      CmdErr        <= CMDERR_NONE;
      Data0Out      <= 32'd0;
      Data0We       <= 1'b0;
      HaltReq       <= 1'b0;
      ResumeReq     <= 1'b0;
      DebugControl  <= 1'b0;
      RegAddr       <= 5'd0;
      RegIn         <= 32'd0;
      DebugRegWrite <= 1'b0;
    end else begin
      state_r       <= state_s;
      CmdBusy       <= (state_s != ST_IDLE);
      CmdErr        <= err_s;
      Data0Out      <= d0out_s;
      Data0We       <= d0we_s;
      HaltReq       <= halt_s;
      ResumeReq     <= resume_s;
      DebugControl  <= ctl_s;
      RegAddr       <= addr_s;
      RegIn         <= regin_s;
      DebugRegWrite <= regwr_s;
    end
  end

  // command fields captured at acceptance
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      regno_r <= 5'd0;
      write_r <= 1'b0;
      data0_r <= 32'd0;
    end else if (latch_s) begin
      regno_r <= CmdRegno[4:0];
      write_r <= CmdWrite;
      data0_r <= Data0In;
    end else begin
      regno_r <= regno_r;
      write_r <= write_r;
      data0_r <= data0_r;
    end
  end

`ifdef ABSTRACT_AUTOHALT_EN
  // remembers whether this command issued the halt and so owes a resume
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      auto_r <= 1'b0;
    end else if (latch_s) begin
      auto_r <= !DebugMode;
    end else begin
      auto_r <= auto_r;
    end
  end
`endif

endmodule

// File: tb/tb_abstract_cmd_seq.sv
// Directed bench for abstract_cmd_seq with a read-data scoreboard and a small
// register-file model behind the debug port.
module tb_abstract_cmd_seq;

  localparam int HT = 20;

  logic        clk = 1'b0;
  logic        sys_reset;
  logic        CmdValid, CmdWrite, CmdTransfer, CmdPostexec, CmdErrClr;
  logic [15:0] CmdRegno;
  logic [2:0]  CmdAarsize;
  logic [31:0] Data0In;
  logic        CmdBusy;
  logic [2:0]  CmdErr;
  logic [31:0] Data0Out;
  logic        Data0We;
  logic        DebugMode;
  logic        HaltReq, ResumeReq, DebugControl, DebugRegWrite;
  logic [4:0]  RegAddr;
  logic [31:0] RegIn, RegOut;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses = 0;
  int dc_cycles = 0;
  int wr0, dc0, n;
  logic [31:0] sb [$];

  logic [31:0] regs [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  abstract_cmd_seq #(.HALT_TIMEOUT(HT)) dut (
    .clk(clk), .sys_reset(sys_reset), .CmdValid(CmdValid), .CmdRegno(CmdRegno),
    .CmdWrite(CmdWrite), .CmdTransfer(CmdTransfer), .CmdPostexec(CmdPostexec),
    .CmdAarsize(CmdAarsize), .Data0In(Data0In), .CmdErrClr(CmdErrClr),
    .CmdBusy(CmdBusy), .CmdErr(CmdErr), .Data0Out(Data0Out), .Data0We(Data0We),
    .DebugMode(DebugMode), .HaltReq(HaltReq), .ResumeReq(ResumeReq),
    .DebugControl(DebugControl), .RegAddr(RegAddr), .RegIn(RegIn),
    .DebugRegWrite(DebugRegWrite), .RegOut(RegOut)
  );

  // core register file behind the debug port
  assign RegOut = regs[RegAddr];
  always @(posedge clk) begin
    if (pl_en) regs[pl_addr] <= pl_data;
    else if (DebugRegWrite) regs[RegAddr] <= RegIn;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // activity counters and read-data scoreboard
  always @(negedge clk) begin
    if (DebugRegWrite === 1'b1) wr_pulses <= wr_pulses + 1;
    if (DebugControl === 1'b1) dc_cycles <= dc_cycles + 1;
    if (Data0We === 1'b1) begin
      if (sb.size() == 0) chk("d0we_unexpected", {31'd0, Data0We}, 32'd0);
      else chk("data0", Data0Out, sb.pop_front());
    end
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // drive one command for one cycle; returns at the negedge of cycle 1
  task automatic issue(input logic [15:0] regno, input logic wr, input logic tr,
                       input logic pe, input logic [2:0] sz, input logic [31:0] d);
    CmdRegno = regno; CmdWrite = wr; CmdTransfer = tr; CmdPostexec = pe;
    CmdAarsize = sz; Data0In = d; CmdValid = 1'b1;
    @(negedge clk);
    CmdValid = 1'b0;
  endtask

  task automatic clr_err();
    CmdErrClr = 1'b1;
    @(negedge clk);
    CmdErrClr = 1'b0;
    chk("err_clr", {29'd0, CmdErr}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    sys_reset = 1'b1; CmdValid = 1'b0; CmdRegno = 16'd0; CmdWrite = 1'b0;
    CmdTransfer = 1'b0; CmdPostexec = 1'b0; CmdAarsize = 3'd0; Data0In = 32'd0;
    CmdErrClr = 1'b0; DebugMode = 1'b0; pl_en = 1'b0; pl_addr = 5'd0; pl_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, CmdBusy}, 32'd0);
    chk("rst_err", {29'd0, CmdErr}, 32'd0);
    chk("rst_d0", Data0Out, 32'd0);
    chk("rst_ctl", {22'd0, Data0We, DebugControl, DebugRegWrite, HaltReq, ResumeReq, RegAddr}, 32'd0);
    chk("rst_regin", RegIn, 32'd0);
    sys_reset = 1'b0;
    DebugMode = 1'b1;
    preload(5'd0, 32'hFFFF_FFFF);
    preload(5'd3, 32'h3333_3333);
    preload(5'd5, 32'hDEAD_BEEF);
    preload(5'd7, 32'hCAFE_F00D);

    // halted read of x5
    sb.push_back(32'hDEAD_BEEF);
    issue(16'h1005, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    chk("rd_c1_addr", {27'd0, RegAddr}, 32'd5);
    chk("rd_c1_ctl", {31'd0, DebugControl}, 32'd1);
    chk("rd_c1_busy", {31'd0, CmdBusy}, 32'd1);
    chk("rd_c1_we", {31'd0, Data0We}, 32'd0);
    @(negedge clk);
    chk("rd_c2_we", {31'd0, Data0We}, 32'd1);
    @(negedge clk);
    chk("rd_c3_busy", {31'd0, CmdBusy}, 32'd0);
    chk("rd_c3_ctl", {31'd0, DebugControl}, 32'd0);
    chk("rd_err", {29'd0, CmdErr}, 32'd0);
    chk("rd_hold", Data0Out, 32'hDEAD_BEEF);

    // halted write of x31, then read back
    wr0 = wr_pulses;
    issue(16'h101F, 1'b1, 1'b1, 1'b0, 3'd2, 32'h1234_5678);
    chk("wr_c1_we", {31'd0, DebugRegWrite}, 32'd1);
    chk("wr_c1_addr", {27'd0, RegAddr}, 32'd31);
    chk("wr_c1_data", RegIn, 32'h1234_5678);
    @(negedge clk);
    chk("wr_c2_we", {31'd0, DebugRegWrite}, 32'd0);
    @(negedge clk);
    chk("wr_c3_busy", {31'd0, CmdBusy}, 32'd0);
    chk("wr_pulses", wr_pulses - wr0, 32'd1);
    sb.push_back(32'h1234_5678);
    issue(16'h101F, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    repeat (2) @(negedge clk);

    // x0: reads return 0, writes are suppressed
    sb.push_back(32'd0);
    issue(16'h1000, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    repeat (2) @(negedge clk);
    wr0 = wr_pulses;
    issue(16'h1000, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_5555);
    repeat (2) @(negedge clk);
    chk("x0_nowr", wr_pulses - wr0, 32'd0);
    chk("x0_busy", {31'd0, CmdBusy}, 32'd0);

    // CSR regno: not supported, later commands dropped until cleared
    dc0 = dc_cycles;
    issue(16'h0300, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    chk("csr_err", {29'd0, CmdErr}, 32'd2);
    chk("csr_busy", {31'd0, CmdBusy}, 32'd0);
    issue(16'h1005, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    repeat (2) @(negedge clk);
    chk("drop_err", {29'd0, CmdErr}, 32'd2);
    chk("drop_noctl", dc_cycles - dc0, 32'd0);
    clr_err();

    issue(16'h1005, 1'b0, 1'b1, 1'b0, 3'd3, 32'd0);
    chk("aarsize_err", {29'd0, CmdErr}, 32'd2);
    clr_err();
    issue(16'h1005, 1'b0, 1'b0, 1'b1, 3'd2, 32'd0);
    chk("postexec_err", {29'd0, CmdErr}, 32'd2);
    clr_err();
    issue(16'h0300, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    chk("notransfer_err", {29'd0, CmdErr}, 32'd0);
    chk("notransfer_busy", {31'd0, CmdBusy}, 32'd0);

    // command while busy, coinciding with an error clear: busy wins
    sb.push_back(32'hCAFE_F00D);
    issue(16'h1007, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    CmdValid = 1'b1; CmdErrClr = 1'b1; CmdWrite = 1'b1; CmdRegno = 16'h1003;
    Data0In = 32'h0BAD_0BAD;
    @(negedge clk);
    CmdValid = 1'b0; CmdErrClr = 1'b0;
    chk("busy_err", {29'd0, CmdErr}, 32'd1);
    @(negedge clk);
    chk("busy_done", {31'd0, CmdBusy}, 32'd0);
    clr_err();
    sb.push_back(32'h3333_3333);
    issue(16'h1003, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    repeat (2) @(negedge clk);

    // running core
    DebugMode = 1'b0;
`ifdef ABSTRACT_AUTOHALT_EN
    sb.push_back(32'hDEAD_BEEF);
    issue(16'h1005, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    chk("ah_haltreq", {31'd0, HaltReq}, 32'd1);
    repeat (4) @(negedge clk);
    DebugMode = 1'b1;
    n = 0;
    while (ResumeReq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("ah_resume", {31'd0, ResumeReq}, 32'd1);
    chk("ah_halt_drop", {31'd0, HaltReq}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ah_resume_hold", {31'd0, ResumeReq}, 32'd1);
    DebugMode = 1'b0;
    n = 0;
    while (CmdBusy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("ah_done", {31'd0, CmdBusy}, 32'd0);
    chk("ah_resume_drop", {31'd0, ResumeReq}, 32'd0);
    chk("ah_err", {29'd0, CmdErr}, 32'd0);
    dc0 = dc_cycles;
    issue(16'h1005, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    n = 0;
    while (CmdBusy !== 1'b0 && n < HT + 10) begin @(negedge clk); n++; end
    chk("to_done", {31'd0, CmdBusy}, 32'd0);
    chk("to_err", {29'd0, CmdErr}, 32'd4);
    chk("to_halt_drop", {31'd0, HaltReq}, 32'd0);
    chk("to_noctl", dc_cycles - dc0, 32'd0);
    clr_err();
`else
    dc0 = dc_cycles;
    issue(16'h1005, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0);
    chk("run_err", {29'd0, CmdErr}, 32'd4);
    chk("run_busy", {31'd0, CmdBusy}, 32'd0);
    chk("run_haltreq", {31'd0, HaltReq}, 32'd0);
    @(negedge clk);
    chk("run_noctl", dc_cycles - dc0, 32'd0);
    clr_err();
`endif
    DebugMode = 1'b1;

    // reset during the ACCESS cycle of a write
    issue(16'h1009, 1'b1, 1'b1, 1'b0, 3'd2, 32'hAAAA_5555);
    chk("rsta_we", {31'd0, DebugRegWrite}, 32'd1);
    sys_reset = 1'b1;
    @(negedge clk);
    sys_reset = 1'b0;
    chk("rsta_ctl", {24'd0, CmdBusy, Data0We, DebugControl, DebugRegWrite, HaltReq, ResumeReq, 2'd0}, 32'd0);
    chk("rsta_addr", {27'd0, RegAddr}, 32'd0);
    chk("rsta_err", {29'd0, CmdErr}, 32'd0);
    chk("rsta_d0", Data0Out, 32'd0);
    wr0 = wr_pulses;
    repeat (3) @(negedge clk);
    chk("rsta_nowr", wr_pulses - wr0, 32'd0);
    chk("rsta_idle", {31'd0, CmdBusy}, 32'd0);

    chk("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
